// File: rtl/quad_coverage_seq.sv
// quad_coverage_seq: multi-cycle quad-area and screen-coverage calculator with an exact restoring divider.
// Optional macro QUAD_COVERAGE_ROUND_EN rounds the percentage half-up instead of truncating it.
module quad_coverage_seq #(
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    localparam int PW   = XW + YW + 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [XW-1:0] x1,
    input  logic [XW-1:0] x2,
    input  logic [XW-1:0] x3,
    input  logic [XW-1:0] x4,
    input  logic [YW-1:0] y1,
    input  logic [YW-1:0] y2,
    input  logic [YW-1:0] y3,
    input  logic [YW-1:0] y4,
    output logic          busy,
    output logic          done,
    output logic [6:0]    percent_kept,
    output logic [6:0]    percent_lost,
    output logic [PW-1:0] area2,
    output logic          clamped
);
    localparam int NW  = PW + 7;
    localparam int DEN = 2 * H_RES * V_RES;
    localparam int RW  = $clog2(DEN + 1) + 1;
    localparam int CW  = $clog2(NW);
    localparam logic [RW:0] DEN_X = DEN[RW:0];
`ifdef QUAD_COVERAGE_ROUND_EN
    localparam int HALF = DEN / 2;
    localparam logic [RW-1:0] HALF_V = HALF[RW-1:0];
`endif

    typedef enum logic [2:0] {S_IDLE, S_MUL0, S_MUL1, S_PREP, S_DIV, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [3:0][XW-1:0]      xs_q, xs_d;
    logic [3:0][YW-1:0]      ys_q, ys_d;
    logic signed [PW:0]      prod0_q, prod0_d, prod1_q, prod1_d;
    logic [PW-1:0]           area_q, area_d;
    logic [NW-1:0]           num_q, num_d, quo_q, quo_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d, clamped_q, clamped_d;
    logic [6:0]              kept_q, kept_d, lost_q, lost_d;
    logic [PW-1:0]           area2_q, area2_d;

    logic signed [XW:0]      dx13, dx24, mul_a;
    logic signed [YW:0]      dy13, dy24, mul_b;
    logic signed [PW:0]      ma, mb, mul_p, diff;
    logic [PW-1:0]           abs_v;
    logic [NW-1:0]           a_ext, q_fin;
    logic [RW:0]             trial;
    logic                    ge;

    always_comb begin
        state_d   = state_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        prod0_d   = prod0_q;
        prod1_d   = prod1_q;
        area_d    = area_q;
        num_d     = num_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        kept_d    = kept_q;
        lost_d    = lost_q;
        area2_d   = area2_q;
        clamped_d = clamped_q;

        dx13  = $signed({1'b0, xs_q[0]}) - $signed({1'b0, xs_q[2]});
        dx24  = $signed({1'b0, xs_q[1]}) - $signed({1'b0, xs_q[3]});
        dy13  = $signed({1'b0, ys_q[0]}) - $signed({1'b0, ys_q[2]});
        dy24  = $signed({1'b0, ys_q[1]}) - $signed({1'b0, ys_q[3]});
        // One multiplier serves both diagonal products, operands steered by state
        mul_a = (state_q == S_MUL1) ? dx24 : dx13;
        mul_b = (state_q == S_MUL1) ? dy13 : dy24;
        ma    = {{(PW - XW){mul_a[XW]}}, mul_a};
        mb    = {{(PW - YW){mul_b[YW]}}, mul_b};
        mul_p = ma * mb;

        diff  = prod0_q - prod1_q;
        abs_v = diff[PW] ? (~diff[PW-1:0] + {{(PW - 1){1'b0}}, 1'b1}) : diff[PW-1:0];
        a_ext = {{(NW - PW){1'b0}}, abs_v};

        trial = {rem_q, num_q[NW-1]};
        ge    = (trial >= DEN_X);

`ifdef QUAD_COVERAGE_ROUND_EN
        q_fin = (rem_q >= HALF_V) ? quo_q + NW'(1) : quo_q;
`else
        q_fin = quo_q;
`endif

        case (state_q)
            S_IDLE: begin
                // The cycle carrying done is not an accept slot
                if (start && !done_q) begin
                    xs_d    = {x4, x3, x2, x1};
                    ys_d    = {y4, y3, y2, y1};
                    state_d = S_MUL0;
                end
            end
            S_MUL0: begin
                prod0_d = mul_p;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                prod1_d = mul_p;
                state_d = S_PREP;
            end
            S_PREP: begin
                area_d  = abs_v;
                num_d   = (a_ext << 6) + (a_ext << 5) + (a_ext << 2);
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d = ge ? RW'(trial - DEN_X) : trial[RW-1:0];
                quo_d = {quo_q[NW-2:0], ge};
                num_d = num_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NW - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (q_fin > NW'(100)) begin
                    kept_d    = 7'd100;
                    lost_d    = 7'd0;
                    clamped_d = 1'b1;
                end else begin
                    kept_d    = q_fin[6:0];
                    lost_d    = 7'd100 - q_fin[6:0];
                    clamped_d = 1'b0;
                end
                area2_d = area_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            xs_q      <= '0;
            ys_q      <= '0;
            prod0_q   <= '0;
            prod1_q   <= '0;
            area_q    <= '0;
            num_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            kept_q    <= 7'd0;
            lost_q    <= 7'd100;
            area2_q   <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            prod0_q   <= prod0_d;
            prod1_q   <= prod1_d;
            area_q    <= area_d;
            num_q     <= num_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            kept_q    <= kept_d;
            lost_q    <= lost_d;
            area2_q   <= area2_d;
            clamped_q <= clamped_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign percent_kept = kept_q;
    assign percent_lost = lost_q;
    assign area2        = area2_q;
    assign clamped      = clamped_q;

endmodule

// File: tb/tb_quad_coverage_seq.sv
// Scoreboard bench for quad_coverage_seq: expected results queued at accept, compared on done.
module tb_quad_coverage_seq;
    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int PW  = XW + YW + 2;
    localparam int NW  = PW + 7;
    localparam int DEN = 2 * 640 * 480;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [XW-1:0] x1, x2, x3, x4;
    logic [YW-1:0] y1, y2, y3, y4;
    logic          busy, done, clamped;
    logic [6:0]    percent_kept, percent_lost;
    logic [PW-1:0] area2;

    always #5 clk = ~clk;

    quad_coverage_seq #(.XW(XW), .YW(YW), .H_RES(640), .V_RES(480)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .busy(busy), .done(done),
        .percent_kept(percent_kept), .percent_lost(percent_lost),
        .area2(area2), .clamped(clamped)
    );

    typedef struct {
        longint area2;
        int     kept;
        int     lost;
        int     clamped;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input longint a, input int k, input int l, input int c);
        exp_t e;
        e.area2 = a; e.kept = k; e.lost = l; e.clamped = c;
        return e;
    endfunction

    function automatic exp_t model(input int cx[4], input int cy[4]);
        longint p0, p1, a, num, q, r;
        p0  = longint'(cx[0] - cx[2]) * longint'(cy[1] - cy[3]);
        p1  = longint'(cy[0] - cy[2]) * longint'(cx[1] - cx[3]);
        a   = p0 - p1;
        if (a < 0) a = -a;
        num = 100 * a;
        q   = num / DEN;
        r   = num % DEN;
`ifdef QUAD_COVERAGE_ROUND_EN
        if (r >= DEN / 2) q++;
`endif
        if (q > 100) return mk(a, 100, 0, 1);
        return mk(a, int'(q), 100 - int'(q), 0);
    endfunction

    task automatic apply(input int cx[4], input int cy[4]);
        x1 = XW'(cx[0]); x2 = XW'(cx[1]); x3 = XW'(cx[2]); x4 = XW'(cx[3]);
        y1 = YW'(cy[0]); y2 = YW'(cy[1]); y3 = YW'(cy[2]); y4 = YW'(cy[3]);
    endtask

    task automatic scramble();
        x1 = XW'($urandom); x2 = XW'($urandom); x3 = XW'($urandom); x4 = XW'($urandom);
        y1 = YW'($urandom); y2 = YW'($urandom); y3 = YW'($urandom); y4 = YW'($urandom);
    endtask

    task automatic accept_op(input int cx[4], input int cy[4], input exp_t e, input bit push);
        @(negedge clk);
        if (done) @(negedge clk);
        apply(cx, cy);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_after_accept", busy, 1);
        if (push) sb.push_back(e);
        scramble();
    endtask

    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (edges < 80) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
        end
        check_val({tag, "_done_seen"}, done, 1);
        check_val({tag, "_busy_at_done"}, busy, 0);
    endtask

    // Results are compared whenever the DUT reports them
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check_val("done_with_result_pending", sb.size(), 1);
            end else begin
                got_e = sb.pop_front();
                check_val("area2", area2, got_e.area2);
                check_val("percent_kept", percent_kept, got_e.kept);
                check_val("percent_lost", percent_lost, got_e.lost);
                check_val("clamped", clamped, got_e.clamped);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_kept"}, percent_kept, 0);
        check_val({tag, "_lost"}, percent_lost, 100);
        check_val({tag, "_area2"}, area2, 0);
        check_val({tag, "_clamped"}, clamped, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   edges;
        int   seen;
        int   rx[4];
        int   ry[4];
        exp_t full_e;

`ifdef QUAD_COVERAGE_ROUND_EN
        full_e = mk(612162, 100, 0, 0);
`else
        full_e = mk(612162, 99, 1, 0);
`endif
        reset_n = 1'b0;
        start   = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Full screen, with latency measured from the accept cycle (cycle 0)
        accept_op('{0, 639, 639, 0}, '{0, 0, 479, 479}, full_e, 1);
        wait_done("full", edges);
        check_val("latency_full", edges + 1, NW + 5);

        accept_op('{0, 320, 320, 0}, '{0, 0, 480, 480}, mk(307200, 50, 50, 0), 1);
        wait_done("half_ccw", edges);
        accept_op('{0, 320, 320, 0}, '{480, 480, 0, 0}, mk(307200, 50, 50, 0), 1);
        wait_done("half_cw", edges);

        accept_op('{0, 1023, 1023, 0}, '{0, 0, 511, 511}, mk(1045506, 100, 0, 1), 1);
        wait_done("oversize", edges);

        accept_op('{5, 5, 5, 5}, '{5, 5, 5, 5}, mk(0, 0, 100, 0), 1);
        wait_done("degenerate", edges);

        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) begin
                rx[k] = int'($urandom_range(0, 1023));
                ry[k] = int'($urandom_range(0, 511));
            end
            accept_op(rx, ry, model(rx, ry), 1);
            wait_done("random", edges);
            check_val("latency_random", edges + 1, NW + 5);
        end

        // A second start while busy must be dropped, not queued
        accept_op('{0, 320, 320, 0}, '{0, 0, 480, 480}, mk(307200, 50, 50, 0), 1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        apply('{0, 1023, 1023, 0}, '{0, 0, 511, 511});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_during_ignored_start", busy, 1);
        wait_done("ignored_start", edges);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_val("no_second_done", seen, 0);

        // start held high: second accept lands on the cycle after done
        @(negedge clk);
        apply('{0, 639, 639, 0}, '{0, 0, 479, 479});
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(full_e);
        check_val("b2b_busy_first", busy, 1);
        wait_done("b2b_first", edges);
        check_val("latency_b2b_first", edges + 1, NW + 5);
        @(negedge clk);
        apply('{0, 320, 320, 0}, '{0, 0, 480, 480});
        sb.push_back(mk(307200, 50, 50, 0));
        @(posedge clk);
        #1;
        check_val("b2b_no_accept_on_done", busy, 0);
        @(posedge clk);
        #1;
        check_val("b2b_accept_next", busy, 1);
        start = 1'b0;
        wait_done("b2b_second", edges);
        check_val("latency_b2b_second", edges + 1, NW + 5);

        // Reset at cycle 15 of a computation aborts it
        accept_op('{0, 1023, 1023, 0}, '{0, 0, 511, 511}, mk(0, 0, 0, 0), 0);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_val("no_done_after_abort", seen, 0);

        accept_op('{0, 1023, 1023, 0}, '{0, 0, 511, 511}, mk(1045506, 100, 0, 1), 1);
        wait_done("after_reset", edges);
        check_val("latency_after_reset", edges + 1, NW + 5);

        repeat (5) @(posedge clk);
        #1;
        check_val("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
